axi4_to_ahb: RTL and testbench

AXI4 slave to AHB-Lite master bridge for the core's external-bus side. It accepts single-beat 64-bit AXI4 reads and writes and replays each one as non-pipelined AHB-Lite transfers. It then returns one AXI response per request. It is the counterpart of the AHB-slave/AXI-master bridge and lets the core's AXI masters reach AHB-only memories and peripherals.

---
 rtl/eh2_pkg.sv | 27 ++
 rtl/axi4_to_ahb_strb_dec.sv | 32 +++
 rtl/axi4_to_ahb.sv | 215 +++++++++++++++++++++
 tb/tb_axi4_to_ahb.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/eh2_pkg.sv
// Shared types and encodings for the AXI4-slave to AHB-Lite-master bridge.
package eh2_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } axi2ahb_state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [3:0] HPROT_DATA_PRIV = 4'b0011;

    // Index of the least significant set bit; 0 when no bit is set.
    function automatic logic [2:0] lowest_set(input logic [7:0] v);
        lowest_set = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) lowest_set = 3'(i);
        end
    endfunction

endpackage

// File: rtl/axi4_to_ahb_strb_dec.sv
// Write-strobe decoder: classifies a strobe as a naturally aligned AHB size
// and reports the lane offset plus the lowest set strobe bit.
module axi4_to_ahb_strb_dec
    import eh2_pkg::*;
(
    input  logic [7:0] wstrb,
    output logic       is_natural,
    output logic [2:0] size,
    output logic [2:0] offset,
    output logic [2:0] low_idx
);

    always_comb begin
        is_natural = 1'b1;
        size       = 3'd0;
        offset     = 3'd0;
        low_idx    = lowest_set(wstrb);
        case (wstrb)
            8'hFF: size = 3'd3;
            8'h0F: size = 3'd2;
            8'hF0: begin size = 3'd2; offset = 3'd4; end
            8'h03: size = 3'd1;
            8'h0C: begin size = 3'd1; offset = 3'd2; end
            8'h30: begin size = 3'd1; offset = 3'd4; end
            8'hC0: begin size = 3'd1; offset = 3'd6; end
            8'h01, 8'h02, 8'h04, 8'h08,
            8'h10, 8'h20, 8'h40, 8'h80: offset = low_idx;
            default: is_natural = 1'b0;
        endcase
    end

endmodule

// File: rtl/axi4_to_ahb.sv
// AXI4 slave to AHB-Lite master bridge, one single-beat request at a time.
// Define AXI4_TO_AHB_STRB_SPLIT_EN to split non-natural write strobes into byte writes.
module axi4_to_ahb
    import eh2_pkg::*;
#(
    parameter int TAG = 1
) (
    input  logic           clk,
    input  logic           rst_l,
    input  logic           scan_mode,
    input  logic           clk_override,
    input  logic           bus_clk_en,

    input  logic           axi_awvalid,
    output logic           axi_awready,
    input  logic [TAG-1:0] axi_awid,
    input  logic [31:0]    axi_awaddr,
    input  logic [2:0]     axi_awsize,

    input  logic           axi_wvalid,
    output logic           axi_wready,
    input  logic [63:0]    axi_wdata,
    input  logic [7:0]     axi_wstrb,

    output logic           axi_bvalid,
    input  logic           axi_bready,
    output logic [1:0]     axi_bresp,
    output logic [TAG-1:0] axi_bid,

    input  logic           axi_arvalid,
    output logic           axi_arready,
    input  logic [TAG-1:0] axi_arid,
    input  logic [31:0]    axi_araddr,
    input  logic [2:0]     axi_arsize,

    output logic           axi_rvalid,
    input  logic           axi_rready,
    output logic [TAG-1:0] axi_rid,
    output logic [63:0]    axi_rdata,
    output logic [1:0]     axi_rresp,
    output logic           axi_rlast,

    output logic [31:0]    ahb_haddr,
    output logic [2:0]     ahb_hsize,
    output logic [1:0]     ahb_htrans,
    output logic           ahb_hwrite,
    output logic [63:0]    ahb_hwdata,
    output logic [2:0]     ahb_hburst,
    output logic [3:0]     ahb_hprot,
    output logic           ahb_hmastlock,

    input  logic [63:0]    ahb_hrdata,
    input  logic           ahb_hready,
    input  logic           ahb_hresp
);

    axi2ahb_state_t state;

    logic [TAG-1:0] cmd_id;
    logic           cmd_write;
    logic           cmd_err;
    logic [7:0]     cmd_strb;
    logic [63:0]    cmd_wdata;
    logic [1:0]     resp_q;

    logic           write_go;
    logic           read_go;
    logic [7:0]     dec_in;
    logic           dec_natural;
    logic [2:0]     dec_size;
    logic [2:0]     dec_offset;
    logic [2:0]     dec_low;
    logic           unused_ok;

    assign write_go = bus_clk_en && (state == IDLE) && axi_awvalid && axi_wvalid;
    assign read_go  = bus_clk_en && (state == IDLE) && axi_arvalid && !(axi_awvalid && axi_wvalid);

    assign axi_awready = write_go;
    assign axi_wready  = write_go;
    assign axi_arready = read_go;

    assign axi_bresp = resp_q;
    assign axi_rresp = resp_q;
    assign axi_bid   = cmd_id;
    assign axi_rid   = cmd_id;

    assign ahb_hburst    = 3'b000;
    assign ahb_hprot     = HPROT_DATA_PRIV;
    assign ahb_hmastlock = 1'b0;

    assign unused_ok = &{1'b0, scan_mode, clk_override, axi_awsize, axi_awaddr[2:0]};

    // Outside IDLE the decoder only serves the remaining split mask.
    assign dec_in = (state == IDLE) ? axi_wstrb : cmd_strb;

    axi4_to_ahb_strb_dec u_strb_dec (
        .wstrb      (dec_in),
        .is_natural (dec_natural),
        .size       (dec_size),
        .offset     (dec_offset),
        .low_idx    (dec_low)
    );

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state      <= IDLE;
            cmd_id     <= '0;
            cmd_write  <= 1'b0;
            cmd_err    <= 1'b0;
            cmd_strb   <= 8'h00;
            cmd_wdata  <= 64'h0;
            resp_q     <= RESP_OKAY;
            axi_bvalid <= 1'b0;
            axi_rvalid <= 1'b0;
            axi_rlast  <= 1'b0;
            axi_rdata  <= 64'h0;
            ahb_haddr  <= 32'h0;
            ahb_hsize  <= 3'd0;
            ahb_htrans <= HTRANS_IDLE;
            ahb_hwrite <= 1'b0;
            ahb_hwdata <= 64'h0;
        end else if (bus_clk_en) begin
            case (state)
                IDLE: begin
                    if (write_go) begin
                        cmd_id     <= axi_awid;
                        cmd_write  <= 1'b1;
                        cmd_err    <= 1'b0;
                        cmd_wdata  <= axi_wdata;
                        ahb_hwrite <= 1'b1;
                        if (axi_wstrb == 8'h00) begin
                            cmd_strb   <= 8'h00;
                            resp_q     <= RESP_OKAY;
                            axi_bvalid <= 1'b1;
                            state      <= RESP;
                        end else if (dec_natural) begin
                            cmd_strb   <= 8'h00;
                            ahb_haddr  <= {axi_awaddr[31:3], dec_offset};
                            ahb_hsize  <= dec_size;
                            ahb_htrans <= HTRANS_NONSEQ;
                            state      <= CMD;
                        end else begin
`ifdef AXI4_TO_AHB_STRB_SPLIT_EN
                            // cmd_strb holds the bytes still to go after this one
                            cmd_strb   <= axi_wstrb & (axi_wstrb - 8'd1);
                            ahb_haddr  <= {axi_awaddr[31:3], dec_low};
                            ahb_hsize  <= 3'd0;
                            ahb_htrans <= HTRANS_NONSEQ;
                            state      <= CMD;
`else
                            cmd_strb   <= 8'h00;
                            resp_q     <= RESP_SLVERR;
                            axi_bvalid <= 1'b1;
                            state      <= RESP;
`endif
                        end
                    end else if (read_go) begin
                        cmd_id     <= axi_arid;
                        cmd_write  <= 1'b0;
                        cmd_err    <= 1'b0;
                        cmd_strb   <= 8'h00;
                        ahb_haddr  <= axi_araddr;
                        ahb_hsize  <= axi_arsize;
                        ahb_hwrite <= 1'b0;
                        ahb_htrans <= HTRANS_NONSEQ;
                        state      <= CMD;
                    end
                end

                CMD: begin
                    if (ahb_hready) begin
                        ahb_htrans <= HTRANS_IDLE;
                        ahb_hwdata <= cmd_wdata;
                        state      <= DATA;
                    end
                end

                DATA: begin
                    if (ahb_hresp) cmd_err <= 1'b1;
                    if (ahb_hready) begin
                        if (!cmd_write) axi_rdata <= ahb_hrdata;
                        if (!ahb_hresp && !cmd_err && (cmd_strb != 8'h00)) begin
                            ahb_haddr  <= {ahb_haddr[31:3], dec_low};
                            ahb_htrans <= HTRANS_NONSEQ;
                            cmd_strb   <= cmd_strb & (cmd_strb - 8'd1);
                            state      <= CMD;
                        end else begin
                            cmd_strb <= 8'h00;
                            resp_q   <= (ahb_hresp || cmd_err) ? RESP_SLVERR : RESP_OKAY;
                            if (cmd_write) begin
                                axi_bvalid <= 1'b1;
                            end else begin
                                axi_rvalid <= 1'b1;
                                axi_rlast  <= 1'b1;
                            end
                            state <= RESP;
                        end
                    end
                end

                RESP: begin
                    if (cmd_write ? axi_bready : axi_rready) begin
                        axi_bvalid <= 1'b0;
                        axi_rvalid <= 1'b0;
                        axi_rlast  <= 1'b0;
                        state      <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_to_ahb.sv
// Directed self-checking bench for axi4_to_ahb; honours AXI4_TO_AHB_STRB_SPLIT_EN.
module tb_axi4_to_ahb;

    localparam int TAG = 1;

    logic           clk = 1'b0;
    logic           rst_l;
    logic           scan_mode, clk_override, bus_clk_en;
    logic           awvalid, awready, wvalid, wready, bvalid, bready;
    logic [TAG-1:0] awid, bid, arid, rid;
    logic [31:0]    awaddr, araddr;
    logic [2:0]     awsize, arsize;
    logic [63:0]    wdata, rdata;
    logic [7:0]     wstrb;
    logic [1:0]     bresp, rresp;
    logic           arvalid, arready, rvalid, rready, rlast;
    logic [31:0]    haddr;
    logic [2:0]     hsize, hburst;
    logic [1:0]     htrans;
    logic           hwrite, hmastlock, hready, hresp;
    logic [63:0]    hwdata, hrdata;
    logic [3:0]     hprot;

    int checks = 0;
    int failures = 0;

    int          nbeats, b_cyc, r_cyc, bp_viol;
    logic [31:0] beat_addr [8];
    logic [2:0]  beat_size [8];
    logic        beat_write [8];
    logic [63:0] beat_wdata [8];
    logic [1:0]  bresp_s, rresp_s;
    logic [TAG-1:0] bid_s, rid_s;
    logic [63:0] rdata_s;
    logic        rlast_s, rdy_aw, rdy_w, rdy_ar, all_done;

    always #5 clk = ~clk;

    axi4_to_ahb #(.TAG(TAG)) dut (
        .clk(clk), .rst_l(rst_l), .scan_mode(scan_mode), .clk_override(clk_override), .bus_clk_en(bus_clk_en),
        .axi_awvalid(awvalid), .axi_awready(awready), .axi_awid(awid), .axi_awaddr(awaddr), .axi_awsize(awsize),
        .axi_wvalid(wvalid), .axi_wready(wready), .axi_wdata(wdata), .axi_wstrb(wstrb),
        .axi_bvalid(bvalid), .axi_bready(bready), .axi_bresp(bresp), .axi_bid(bid),
        .axi_arvalid(arvalid), .axi_arready(arready), .axi_arid(arid), .axi_araddr(araddr), .axi_arsize(arsize),
        .axi_rvalid(rvalid), .axi_rready(rready), .axi_rid(rid), .axi_rdata(rdata), .axi_rresp(rresp), .axi_rlast(rlast),
        .ahb_haddr(haddr), .ahb_hsize(hsize), .ahb_htrans(htrans), .ahb_hwrite(hwrite), .ahb_hwdata(hwdata),
        .ahb_hburst(hburst), .ahb_hprot(hprot), .ahb_hmastlock(hmastlock),
        .ahb_hrdata(hrdata), .ahb_hready(hready), .ahb_hresp(hresp)
    );

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Issues a write and/or read, acts as the AHB slave and collects responses.
    // Cycle 0 is the cycle in which the request is first presented.
    task automatic applyStimulus(
        input bit do_w, input logic [31:0] waddr, input logic [63:0] wdat, input logic [7:0] strb, input logic [TAG-1:0] wid,
        input bit do_r, input logic [31:0] raddr, input logic [2:0] rsize, input logic [TAG-1:0] rid_in,
        input int waits, input logic [63:0] rd, input bit err, input int bp);
        bit b_done, r_done, in_data, clr_w, clr_r;
        int wait_left, hold;
        nbeats = 0; b_cyc = -1; r_cyc = -1; bp_viol = 0; hold = 0; wait_left = 0;
        b_done = !do_w; r_done = !do_r; in_data = 0; clr_w = 0; clr_r = 0;
        @(posedge clk); #1;
        if (do_w) begin awvalid = 1; wvalid = 1; awaddr = waddr; wdata = wdat; wstrb = strb; awid = wid; awsize = 3'd3; end
        if (do_r) begin arvalid = 1; araddr = raddr; arsize = rsize; arid = rid_in; end
        bready = 0; rready = 0; hready = 1; hresp = 0;
        for (int c = 0; c < 80 && !(b_done && r_done); c++) begin
            @(negedge clk);
            if (c == 0) begin rdy_aw = awready; rdy_w = wready; rdy_ar = arready; end
            if (clr_w) begin awvalid = 0; wvalid = 0; end
            if (clr_r) arvalid = 0;
            if (awvalid && awready) clr_w = 1;
            if (arvalid && arready) clr_r = 1;
            if (in_data) begin
                if (wait_left > 0) begin
                    hready = 0; hresp = err; wait_left--;
                end else begin
                    hready = 1; hresp = err; hrdata = rd; beat_wdata[nbeats-1] = hwdata; in_data = 0;
                end
            end else begin
                hready = 1; hresp = 0;
                if (htrans == 2'b10 && nbeats < 8) begin
                    beat_addr[nbeats] = haddr; beat_size[nbeats] = hsize; beat_write[nbeats] = hwrite;
                    nbeats++; in_data = 1; wait_left = waits;
                end
            end
            if (bvalid && !b_done) begin
                if (b_cyc < 0) begin b_cyc = c; bresp_s = bresp; bid_s = bid; end
                if (arready) bp_viol++;
                if (hold < bp) begin bready = 0; hold++; end
                else begin bready = 1; b_done = 1; end
            end else if (b_cyc >= 0 && !b_done) begin
                bp_viol++;
            end
            if (rvalid && !r_done) begin
                r_cyc = c; rresp_s = rresp; rid_s = rid; rdata_s = rdata; rlast_s = rlast;
                rready = 1; r_done = 1;
            end
        end
        all_done = b_done && r_done;
        @(posedge clk); #1;
        bready = 0; rready = 0; awvalid = 0; wvalid = 0; arvalid = 0; hresp = 0; hready = 1;
        checkOutput("txn_done", all_done, 1);
    endtask

    initial begin
        int cnt;
        bit found;
        rst_l = 0; scan_mode = 0; clk_override = 0; bus_clk_en = 1;
        awvalid = 0; wvalid = 0; arvalid = 0; bready = 0; rready = 0;
        awid = 0; arid = 0; awaddr = 0; araddr = 0; awsize = 0; arsize = 0; wdata = 0; wstrb = 0;
        hready = 1; hresp = 0; hrdata = 0;

        repeat (3) @(negedge clk);
        checkOutput("rst_valids", {bvalid, rvalid, rlast, awready, wready, arready}, 0);
        checkOutput("rst_htrans", htrans, 0);
        checkOutput("rst_haddr", haddr, 0);
        checkOutput("rst_hwdata", hwdata, 0);
        checkOutput("rst_rdata", rdata, 0);
        checkOutput("const_ctrl", {hburst, hprot, hmastlock}, {3'b000, 4'b0011, 1'b0});
        rst_l = 1;
        repeat (2) @(negedge clk);

        // Aligned 64-bit write, zero-wait slave
        applyStimulus(1, 32'h1000, 64'h1122334455667788, 8'hFF, 1'b1, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("w64_ready", {rdy_aw, rdy_w}, 2'b11);
        checkOutput("w64_beats", nbeats, 1);
        checkOutput("w64_haddr", beat_addr[0], 32'h1000);
        checkOutput("w64_hsize", beat_size[0], 3);
        checkOutput("w64_hwrite", beat_write[0], 1);
        checkOutput("w64_hwdata", beat_wdata[0], 64'h1122334455667788);
        checkOutput("w64_bcycle", b_cyc, 3);
        checkOutput("w64_bresp", bresp_s, 0);
        checkOutput("w64_bid", bid_s, 1);
        @(negedge clk);
        checkOutput("w64_bvalid_clr", bvalid, 0);

        // Read with two wait states
        applyStimulus(0, 0, 0, 0, 0, 1, 32'h2004, 3'd2, 1'b1, 2, 64'hDEADBEEF_00000000, 0, 0);
        checkOutput("rd_ready", rdy_ar, 1);
        checkOutput("rd_beats", nbeats, 1);
        checkOutput("rd_haddr", beat_addr[0], 32'h2004);
        checkOutput("rd_hsize", beat_size[0], 2);
        checkOutput("rd_hwrite", beat_write[0], 0);
        checkOutput("rd_rcycle", r_cyc, 5);
        checkOutput("rd_rdata", rdata_s, 64'hDEADBEEF_00000000);
        checkOutput("rd_rresp", rresp_s, 0);
        checkOutput("rd_rlast", rlast_s, 1);
        checkOutput("rd_rid", rid_s, 1);

        // Upper word and halfword lanes
        applyStimulus(1, 32'h3000, 64'hAAAA_BBBB_0000_0000, 8'hF0, 1'b0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("wup_haddr", beat_addr[0], 32'h3004);
        checkOutput("wup_hsize", beat_size[0], 2);
        checkOutput("wup_bresp", bresp_s, 0);
        applyStimulus(1, 32'h5000, 64'h0, 8'h0C, 1'b0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("whw_haddr", beat_addr[0], 32'h5002);
        checkOutput("whw_hsize", beat_size[0], 1);

        // Non-natural strobe 0x05
        applyStimulus(1, 32'h4000, 64'h0000_0000_0033_0011, 8'h05, 1'b1, 0, 0, 0, 0, 0, 0, 0, 0);
`ifdef AXI4_TO_AHB_STRB_SPLIT_EN
        checkOutput("split_beats", nbeats, 2);
        checkOutput("split_addr0", beat_addr[0], 32'h4000);
        checkOutput("split_addr1", beat_addr[1], 32'h4002);
        checkOutput("split_sizes", {beat_size[0], beat_size[1]}, 0);
        checkOutput("split_bcycle", b_cyc, 5);
        checkOutput("split_bresp", bresp_s, 0);
`else
        checkOutput("split_beats", nbeats, 0);
        checkOutput("split_bcycle", b_cyc, 1);
        checkOutput("split_bresp", bresp_s, 2);
`endif
        checkOutput("split_bid", bid_s, 1);

        // Empty strobe
        applyStimulus(1, 32'h4800, 64'h0, 8'h00, 1'b0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("zero_beats", nbeats, 0);
        checkOutput("zero_bcycle", b_cyc, 1);
        checkOutput("zero_bresp", bresp_s, 0);

        // Read error with a two-cycle AHB error response
        applyStimulus(0, 0, 0, 0, 0, 1, 32'h2000, 3'd3, 1'b0, 1, 64'h0, 1, 0);
        checkOutput("rerr_beats", nbeats, 1);
        checkOutput("rerr_rcycle", r_cyc, 4);
        checkOutput("rerr_rresp", rresp_s, 2);

        // Error on the first split byte drops the remaining byte
        applyStimulus(1, 32'h4000, 64'h0, 8'h05, 1'b0, 0, 0, 0, 0, 0, 0, 1, 0);
`ifdef AXI4_TO_AHB_STRB_SPLIT_EN
        checkOutput("serr_beats", nbeats, 1);
        checkOutput("serr_bcycle", b_cyc, 3);
`else
        checkOutput("serr_beats", nbeats, 0);
        checkOutput("serr_bcycle", b_cyc, 1);
`endif
        checkOutput("serr_bresp", bresp_s, 2);

        // Contention plus 5 cycles of write-response backpressure
        applyStimulus(1, 32'h6000, 64'h55, 8'hFF, 1'b1, 1, 32'h7000, 3'd3, 1'b0, 0, 64'h0123_4567_89AB_CDEF, 0, 5);
        checkOutput("cont_ready", {rdy_aw, rdy_w, rdy_ar}, 3'b110);
        checkOutput("cont_beats", nbeats, 2);
        checkOutput("cont_order", {beat_write[0], beat_write[1]}, 2'b10);
        checkOutput("cont_raddr", beat_addr[1], 32'h7000);
        checkOutput("cont_bcycle", b_cyc, 3);
        checkOutput("cont_bp_hold", bp_viol, 0);
        checkOutput("cont_rcycle", r_cyc, 12);
        checkOutput("cont_rdata", rdata_s, 64'h0123_4567_89AB_CDEF);
        checkOutput("cont_rid", rid_s, 0);

        // bus_clk_en low: readies forced off, state frozen
        @(posedge clk); #1;
        bus_clk_en = 0; awvalid = 1; wvalid = 1; awaddr = 32'h8000; wstrb = 8'hFF; awid = 0;
        @(negedge clk);
        checkOutput("clken_ready", {awready, wready}, 0);
        bus_clk_en = 1;
        @(posedge clk); #1;
        awvalid = 0; wvalid = 0; bus_clk_en = 0;
        repeat (3) @(negedge clk);
        checkOutput("clken_freeze", htrans, 2'b10);
        checkOutput("clken_nobvalid", bvalid, 0);
        bus_clk_en = 1; bready = 1; found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (bvalid) found = 1;
        end
        checkOutput("clken_resume", found, 1);
        @(posedge clk); #1; bready = 0;

        // Reset in the middle of a transfer
        @(posedge clk); #1;
        awvalid = 1; wvalid = 1; awaddr = 32'h9000; wstrb = 8'hFF;
        @(posedge clk); #1;
        awvalid = 0; wvalid = 0;
        @(negedge clk);
        rst_l = 0;
        #1;
        checkOutput("rst_mid_htrans", htrans, 0);
        checkOutput("rst_mid_haddr", haddr, 0);
        @(negedge clk);
        rst_l = 1; bready = 1; cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (bvalid) cnt++;
        end
        checkOutput("rst_mid_noresp", cnt, 0);
        bready = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
